// File: rtl/ps2_pkg.sv
// Shared PS/2 key-event types and constants for the keyboard-input datapath.
// Used by ps2_key_event_sequencer (PS2_EXTENDED_EN build option) and ps2_event_fifo.
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;
  localparam logic [7:0] PS2_ERR_00       = 8'h00;
  localparam logic [7:0] PS2_ERR_FF       = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GOT_E0   = 2'd1,
    ST_GOT_F0   = 2'd2,
    ST_GOT_E0F0 = 2'd3
  } ps2_state_e;

  typedef struct packed {
    logic       extended;
    logic       key_release;
    logic [7:0] code;
  } key_event_t;

  function automatic logic is_err_code(input logic [7:0] b);
    return (b == PS2_ERR_00) || (b == PS2_ERR_FF);
  endfunction

endpackage

// File: rtl/ps2_key_event_sequencer_if.sv
// Receive-frame and key-event bus of ps2_key_event_sequencer.
// slave = sequencer side, master = frame source / event consumer side.
interface ps2_key_event_sequencer_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_error;
  logic          event_ready;
  logic          event_valid;
  logic [7:0]    event_code;
  logic          event_release;
  logic          event_extended;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          error_flag;
  logic          flags_clr;

  modport slave (
    input  rx_valid, rx_data, rx_error, event_ready, flags_clr,
    output event_valid, event_code, event_release, event_extended,
    output fifo_count, overflow, error_flag
  );

  modport master (
    output rx_valid, rx_data, rx_error, event_ready, flags_clr,
    input  event_valid, event_code, event_release, event_extended,
    input  fifo_count, overflow, error_flag
  );
endinterface

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through FIFO of key_event_t with occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset_neg,
  input  logic                       i_push,
  input  key_event_t                 i_data,
  input  logic                       i_pop,
  output key_event_t                 o_head,
  output logic                       o_valid,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  key_event_t    r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_valid   = (r_count != '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = i_pop && o_valid;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_head    = r_mem[r_rd];
  assign o_count   = r_count;

  // Storage is reset so the head reads as zero out of reset.
  always_ff @(posedge clock or negedge reset_neg) begin
    if (!reset_neg) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_do_pop) r_rd <= r_rd + AW'(1);
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/ps2_key_event_sequencer.sv
// Turns PS/2 frames into make/break key events with repeat filtering and an event FIFO.
// Build option PS2_EXTENDED_EN: enables 0xE0 extended-key handling and event_extended.
//
// state       | meaning
// ST_IDLE     | waiting for a prefix or a make code
// ST_GOT_E0   | extended prefix seen, waiting for code or 0xF0
// ST_GOT_F0   | break prefix seen, waiting for code
// ST_GOT_E0F0 | extended break prefix seen, waiting for code
module ps2_key_event_sequencer
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          clock,
  input  logic                          reset_neg,
  ps2_key_event_sequencer_if.slave      bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  ps2_state_e    r_state;
  ps2_state_e    w_state_nxt;
  logic [TW-1:0] r_tmo;
  logic [TW-1:0] w_tmo_nxt;
  logic [8:0]    r_last_make;
  logic [8:0]    w_last_nxt;
  logic [8:0]    w_key;
  logic          r_ovf;
  logic          r_err;
  logic          w_err_set;
  logic          w_gen;
  logic          w_push;
  logic          w_pop;
  logic          w_valid;
  logic          w_full;
  logic [CW-1:0] w_count;
  key_event_t    w_evt;
  key_event_t    w_head;

  always_ff @(posedge clock or negedge reset_neg) begin
    if (!reset_neg) begin
      r_state     <= ST_IDLE;
      r_tmo       <= '0;
      r_last_make <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_tmo       <= w_tmo_nxt;
      r_last_make <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err_set   = 1'b0;
    w_gen       = 1'b0;
    w_evt       = '0;
    if (bus.rx_valid) begin
      if (bus.rx_error || is_err_code(bus.rx_data)) begin
        w_err_set   = 1'b1;
        w_state_nxt = ST_IDLE;
      end else if (bus.rx_data == PS2_PREFIX_EXT) begin
`ifdef PS2_EXTENDED_EN
        if (r_state == ST_IDLE) begin
          w_state_nxt = ST_GOT_E0;
        end else begin
          w_err_set   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
`endif
      end else if (bus.rx_data == PS2_PREFIX_BREAK) begin
        case (r_state)
          ST_IDLE:   w_state_nxt = ST_GOT_F0;
          ST_GOT_E0: w_state_nxt = ST_GOT_E0F0;
          default: begin
            w_err_set   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        endcase
      end else begin
        w_gen             = 1'b1;
        w_evt.code        = bus.rx_data;
        w_evt.key_release = (r_state == ST_GOT_F0) || (r_state == ST_GOT_E0F0);
`ifdef PS2_EXTENDED_EN
        w_evt.extended    = (r_state == ST_GOT_E0) || (r_state == ST_GOT_E0F0);
`else
        w_evt.extended    = 1'b0;
`endif
        w_state_nxt       = ST_IDLE;
      end
    end else if ((r_state != ST_IDLE) && (r_tmo == TMO_LAST)) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // Timer restarts on every state change; it saturates so a stale prefix still expires.
  always_comb begin
    w_tmo_nxt = r_tmo;
    if ((w_state_nxt != r_state) || (r_state == ST_IDLE)) w_tmo_nxt = '0;
    else if (r_tmo != TMO_LAST)                           w_tmo_nxt = r_tmo + TW'(1);
  end

  always_comb begin
    w_key      = {w_evt.extended, w_evt.code};
    w_last_nxt = r_last_make;
    w_push     = 1'b0;
    if (w_gen) begin
      if (!w_evt.key_release) begin
        if (w_key != r_last_make) begin
          w_push     = 1'b1;
          w_last_nxt = w_key;
        end
      end else begin
        w_push = 1'b1;
        if (w_key == r_last_make) w_last_nxt = '0;
      end
    end
  end

  assign w_pop = w_valid && bus.event_ready;

  always_ff @(posedge clock or negedge reset_neg) begin
    if (!reset_neg) begin
      r_ovf <= 1'b0;
      r_err <= 1'b0;
    end else if (bus.flags_clr) begin
      r_ovf <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      if (w_err_set)                  r_err <= 1'b1;
    end
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_neg (reset_neg),
    .i_push    (w_push),
    .i_data    (w_evt),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_valid   (w_valid),
    .o_full    (w_full),
    .o_count   (w_count)
  );

  assign bus.event_valid    = w_valid;
  assign bus.event_code     = w_head.code;
  assign bus.event_release  = w_head.key_release;
  assign bus.event_extended = w_head.extended;
  assign bus.fifo_count     = w_count;
  assign bus.overflow       = r_ovf;
  assign bus.error_flag     = r_err;
endmodule

// File: doc/ps2_key_event_sequencer.md
# ps2_key_event_sequencer

Sequences raw PS/2 receive frames into discrete key events for the keyboard-input datapath. Sits between the PS/2 frame receiver (byte plus frame-done strobe) and downstream consumers such as the digit-entry/adder logic and seven-segment drivers. Tracks the 0xE0/0xF0 prefix protocol, suppresses typematic repeats, and buffers events in a small FIFO with a ready/valid handshake.

## Interface
- FIFO_DEPTH, 4, event FIFO entries; power of two, 2..16
- TIMEOUT_CYCLES, 50000, max clock cycles allowed between a prefix byte and its code byte
- clock  input  1  system clock, all logic on rising edge
- reset_neg  input  1  asynchronous active-low reset
- rx_valid  input  1  one-cycle strobe: a frame completed, rx_data valid
- rx_data  input  8  received scan byte (frame bits [8:1])
- rx_error  input  1  qualifies rx_valid: parity/stop-bit failure
- event_ready  input  1  consumer accepts head event
- event_valid  output  1  FIFO non-empty
- event_code  output  8  head event scan code
- event_release  output  1  head event is a break (key up)
- event_extended  output  1  head event carried 0xE0 prefix
- fifo_count  output  $clog2(FIFO_DEPTH)+1  occupied entries
- overflow  output  1  sticky: event dropped because FIFO full
- error_flag  output  1  sticky: frame error or 0x00/0xFF code seen
- flags_clr  input  1  synchronous clear of overflow and error_flag

## Operation
- FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0. Only cycles with rx_valid=1 advance it (plus timeout).
- IDLE: 0xE0→GOT_E0; 0xF0→GOT_F0; other code→make event (ext=0).
- GOT_E0: 0xF0→GOT_E0F0; other code→make event (ext=1), →IDLE.
- GOT_F0: code→break event (ext=0), →IDLE. GOT_E0F0: code→break event (ext=1), →IDLE.
- Prefix byte while already in a state expecting a code: 0xE0 in GOT_E0, or any prefix in GOT_F0/GOT_E0F0 → error_flag set, FSM→IDLE, byte discarded.
- rx_error=1 with rx_valid: byte discarded, error_flag set, FSM→IDLE. 0x00 or 0xFF: same.
- Repeat filter: register last_make {ext,code}, reset 0. Make event equal to last_make is dropped. Other make updates last_make. Break matching last_make clears it to 0. Breaks are never filtered.
- FIFO: push on generated (non-filtered) event; pop when event_valid && event_ready. Full and no pop in same cycle: push dropped, overflow set. Full with simultaneous pop: both occur, count unchanged. Empty: event_valid=0, outputs hold last head contents (don't-care).
- Timeout: counter runs in any non-IDLE state, cleared on entry; reaching TIMEOUT_CYCLES-1 forces IDLE, no event, no flag.
- flags_clr has priority over same-cycle flag set.

## Timing
- Reset values: event_valid 0, event_code 0, event_release 0, event_extended 0, fifo_count 0, overflow 0, error_flag 0; FSM IDLE, last_make 0, timeout counter 0.
- Latency: code byte strobed at edge k is written at edge k; event_valid high in the cycle after edge k.
- Back-to-back rx_valid every cycle supported; throughput one event per cycle.
- fifo_count, flags update at same edge as push/pop.
- Reset mid-prefix or with FIFO occupied: all state discarded immediately; no events survive.

## Configuration
- PS2_EXTENDED_EN defined: full E0 handling as above; event_extended driven.
- Undefined: 0xE0 bytes discarded silently in every state (no flag, no state change); GOT_E0/GOT_E0F0 unreachable and not synthesised; event_extended tied 0; last_make compares code only.

## Structure
- Shared package ps2_pkg: PS2_PREFIX_EXT=8'hE0, PS2_PREFIX_BREAK=8'hF0, PS2_ERR_00/PS2_ERR_FF, FSM state enum, key_event_t struct {extended, release, code[7:0]}.
- One sub-module: ps2_event_fifo (parameterised synchronous FIFO of key_event_t, first-word fall-through, count output).

## Test plan
- rx 0x3E, ready=1 → one event {3E, rel 0, ext 0}, event_valid one cycle after strobe.
- rx 0x3E, 0xF0, 0x3E → events make 3E then break 3E; last_make back to 0.
- rx 0xE0, 0x75, 0xE0, 0xF0, 0x75 → make 75 ext 1, break 75 ext 1 (macro off: make 75, break 75, ext 0).
- rx 0x1E ×5 then 0xF0 0x1E → exactly two events (make, break).
- ready=0, five distinct makes, FIFO_DEPTH 4 → fifo_count 4, overflow 1, first four codes popped in order; flags_clr → overflow 0.
- rx 0xF0, idle TIMEOUT_CYCLES, rx 0x16 → make 16 (not break), error_flag 0; rx_error strobe → error_flag 1, no event.
